// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Optional ACCESS wait-state timeout is enabled by defining APB_ARBITER_TIMEOUT_EN.
module apb_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] grant;
    logic       done;
    logic       prio;
    logic       cur;

    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("apb_arbiter: TIMEOUT_CYC must be at least 1");
    end

`ifdef APB_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             expire;

    // Consecutive PREADY-low ACCESS cycles of the current transfer.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY && !expire) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, round-robin grant and completion decode.
    always_comb begin
        next_state = state;
        grant      = 2'b00;
        done       = 1'b0;
`ifdef APB_ARBITER_TIMEOUT_EN
        expire     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    next_state = SETUP;
                    if (req_valid == 2'b11) begin
                        grant = prio ? 2'b10 : 2'b01;
                    end else begin
                        grant = req_valid;
                    end
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
`ifdef APB_ARBITER_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    expire     = 1'b1;
                    next_state = IDLE;
                end
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        req_ready = grant;
    end

    // APB request/response registers; prio names the requester favoured on a tie.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            prio      <= 1'b0;
            cur       <= 1'b0;
        end else begin
            PSEL      <= (next_state != IDLE);
            PENABLE   <= (next_state == ACCESS);
            rsp_valid <= 2'b00;
            if (|grant) begin
                cur    <= grant[1];
                prio   <= grant[0];
                PWRITE <= grant[1] ? req_write[1] : req_write[0];
                PADDR  <= grant[1] ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
                PWDATA <= grant[1] ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
            end
            if (done) begin
                rsp_valid <= cur ? 2'b10 : 2'b01;
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= PSLVERR;
            end
`ifdef APB_ARBITER_TIMEOUT_EN
            if (expire) begin
                rsp_valid <= cur ? 2'b10 : 2'b01;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: write/read-back, round-robin ties, wait states,
// completer error, mid-transfer reset and (with APB_ARBITER_TIMEOUT_EN) the timeout.
module tb_apb_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic                PCLK = 1'b0;
    logic                PRESETn;
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    int errors = 0;
    int checks = 0;

    apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESETn   = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;

        // Reset values
        step();
        step();
        #1;
        chk("rst_psel",      64'(PSEL),      64'h0);
        chk("rst_penable",   64'(PENABLE),   64'h0);
        chk("rst_pwrite",    64'(PWRITE),    64'h0);
        chk("rst_paddr",     64'(PADDR),     64'h0);
        chk("rst_pwdata",    64'(PWDATA),    64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("rst_rsp_err",   64'(rsp_err),   64'h0);

        // Req0 writes 9 to 0x0
        step();
        PRESETn   = 1'b1;
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr  = {32'h0, 32'h0};
        req_wdata = {32'h0, 32'd9};
        PRDATA    = 32'h55;
        #1;
        chk("wr_ready",    64'(req_ready), 64'h1);
        chk("wr_idle_sel", 64'(PSEL),      64'h0);
        step();
        req_valid = 2'b00;
        #1;
        chk("wr_setup_sel", 64'(PSEL),      64'h1);
        chk("wr_setup_en",  64'(PENABLE),   64'h0);
        chk("wr_paddr",     64'(PADDR),     64'h0);
        chk("wr_pwdata",    64'(PWDATA),    64'd9);
        chk("wr_pwrite",    64'(PWRITE),    64'h1);
        chk("wr_setup_rdy", 64'(req_ready), 64'h0);
        step();
        chk("wr_acc_sel", 64'(PSEL),      64'h1);
        chk("wr_acc_en",  64'(PENABLE),   64'h1);
        chk("wr_acc_rsp", 64'(rsp_valid), 64'h0);
        step();
        chk("wr_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("wr_rsp_err",   64'(rsp_err),   64'h0);
        chk("wr_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("wr_rsp_sel",   64'(PSEL),      64'h0);

        // Read-back of 0x0, granted in the response cycle
        req_valid = 2'b01;
        req_write = 2'b00;
        req_wdata = {32'h0, 32'hDEAD};
        PRDATA    = 32'd9;
        #1;
        chk("rd_b2b_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        #1;
        chk("rd_setup_sel", 64'(PSEL),   64'h1);
        chk("rd_pwrite",    64'(PWRITE), 64'h0);
        step();
        chk("rd_acc_en", 64'(PENABLE), 64'h1);
        step();
        chk("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'd9);
        chk("rd_rsp_err",   64'(rsp_err),   64'h0);
        step();
        chk("rd_rsp_pulse", 64'(rsp_valid), 64'h0);

        // Tie after reset: req0 (0x4) first, then req1 (0x8)
        PRESETn = 1'b0;
        step();
        PRESETn   = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = {32'h8, 32'h4};
        req_wdata = {32'h22, 32'h11};
        #1;
        chk("tie_ready0", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b10;
        #1;
        chk("tie_paddr0",  64'(PADDR),  64'h4);
        chk("tie_pwdata0", 64'(PWDATA), 64'h11);
        step();
        chk("tie_acc_paddr0", 64'(PADDR), 64'h4);
        step();
        chk("tie_rsp0", 64'(rsp_valid), 64'h1);
        req_valid = 2'b11;
        req_addr  = {32'h8, 32'h10};
        req_wdata = {32'h22, 32'h33};
        #1;
        chk("rr_ready1", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b01;
        #1;
        chk("tie_paddr1",  64'(PADDR),  64'h8);
        chk("tie_pwdata1", 64'(PWDATA), 64'h22);
        step();
        step();
        chk("tie_rsp1", 64'(rsp_valid), 64'h2);
        chk("rr_ready0", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        #1;
        chk("rr_paddr2", 64'(PADDR), 64'h10);
        step();
        step();
        chk("rr_rsp2", 64'(rsp_valid), 64'h1);

        // Read 0xC with three wait states
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr  = {32'h0, 32'hC};
        PREADY    = 1'b0;
        PRDATA    = 32'h4D616B73;
        #1;
        chk("ws_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        #1;
        chk("ws_setup_paddr", 64'(PADDR), 64'hC);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_wait_en",    64'(PENABLE),   64'h1);
            chk("ws_wait_paddr", 64'(PADDR),     64'hC);
            chk("ws_wait_rsp",   64'(rsp_valid), 64'h0);
        end
        step();
        PREADY = 1'b1;
        #1;
        chk("ws_last_en",    64'(PENABLE), 64'h1);
        chk("ws_last_paddr", 64'(PADDR),   64'hC);
        step();
        chk("ws_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("ws_rsp_rdata", 64'(rsp_rdata), 64'h4D616B73);
        chk("ws_idle_sel",  64'(PSEL),      64'h0);

        // Completer error on a write
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr  = {32'h0, 32'h4};
        PSLVERR   = 1'b1;
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("err_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("err_rsp_err",   64'(rsp_err),   64'h1);
        PSLVERR = 1'b0;

        // Reset during ACCESS aborts the transfer and restores req0 tie priority
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr  = {32'h0, 32'h8};
        PREADY    = 1'b0;
        step();
        req_valid = 2'b00;
        step();
        chk("mid_acc_en", 64'(PENABLE), 64'h1);
        PRESETn = 1'b0;
        step();
        chk("mid_rst_sel", 64'(PSEL),      64'h0);
        chk("mid_rst_en",  64'(PENABLE),   64'h0);
        chk("mid_rst_rsp", 64'(rsp_valid), 64'h0);
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        step();
        chk("mid_no_rsp", 64'(rsp_valid), 64'h0);
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = {32'h8, 32'h0};
        #1;
        chk("mid_tie_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("mid_after_rsp", 64'(rsp_valid), 64'h1);

`ifdef APB_ARBITER_TIMEOUT_EN
        // Timeout after 16 PREADY-low ACCESS cycles
        req_valid = 2'b01;
        req_write = 2'b00;
        PREADY    = 1'b0;
        PRDATA    = 32'h1234;
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("to_wait_sel", 64'(PSEL),      64'h1);
            chk("to_wait_rsp", 64'(rsp_valid), 64'h0);
        end
        step();
        chk("to_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("to_rsp_err",   64'(rsp_err),   64'h1);
        chk("to_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("to_sel",       64'(PSEL),      64'h0);
        PREADY = 1'b1;
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
